pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline boundary register for the five-stage MIPS core; replaces the fixed-field per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Carries an opaque payload (instr, ALU result, rt data, PC, write-enable, write address, write data, packed by the instantiating stage) with a valid/ready handshake, stall support, synchronous flush and an optional skid entry for full throughput under back-pressure.

Parameters:
- DATA_W, 134, payload width in bits (EX/MEM packing: 32+32+32+32+1+5 = 134; RegData is added by the instantiating stage if it is needed).
- SKID, 1, 0 = single entry with combinational in_ready; 1 = two entries (main + skid) with registered in_ready.
- RESET_VAL, 0, payload value loaded on reset and on flush (all-zero instr = sll $0 = nop).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high; clock clk.
- flush  input  1  synchronous kill of all held entries (branch/exception squash).
- in_valid  input  1  upstream stage has a payload.
- in_ready  output  1  block can accept the payload this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data holds a live entry.
- out_ready  input  1  downstream consumes this cycle (low = stall).
- out_data  output  DATA_W  registered payload of the main entry.
- occ  output  2  entries held (0..2; 0..1 when SKID=0).

Behaviour:
- Handshakes:
  - Accept = in_valid & in_ready.
  - Issue = out_valid & out_ready.
  - out_data and out_valid come straight from registers; there is no combinational path from in_data to out_data.
- Reset:
  - out_valid=0, skid_valid=0, occ=0.
  - out_data and skid data = RESET_VAL.
  - in_ready=1 from the first cycle after reset.
  - Reset dominates flush and all handshakes; a reset mid-transfer drops every entry.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - Accept: main <= in_data and out_valid <= 1 next edge; latency 1 cycle.
  - Issue without accept: out_valid <= 0; out_data holds its last value.
  - Issue with accept in the same cycle: main is replaced, out_valid stays 1.
- SKID=1:
  - in_ready = ~skid_valid (registered).
  - Main empty, or main issuing: accepted data goes to main.
  - Main full and stalled (out_ready=0): accepted data goes to skid, skid_valid <= 1.
  - Issue while skid_valid: main <= skid, skid_valid <= 0. A new accept in that cycle is impossible because in_ready=0.
  - Throughput is 1 entry/cycle with no bubble when out_ready toggles.
  - Ordering is strictly FIFO.
- Flush (when ~reset):
  - Next edge: out_valid=0, skid_valid=0, occ=0, main and skid data = RESET_VAL.
  - An accept in the flush cycle is discarded; the upstream transfer still counts as done.
  - An issue in the flush cycle still completes downstream; the entry presented that cycle is consumed, not squashed.
  - in_ready=1 in the cycle after a flush.
- occ = out_valid + skid_valid, updated on the same edge as the valid bits.
- Stall hold: while out_ready=0, out_data and out_valid are stable and never change.
- Invariant: skid_valid=1 implies out_valid=1.

Decomposition:
- Shared package: stage payload widths as constants (INSTR_W=32, ADDR_W=5, the per-stage DATA_W sums) and the NOP instruction constant used for RESET_VAL.
- The core pipeline-field pack/unpack macros also go in the package.
- One natural sub-module, pipe_entry: a DATA_W register with load-enable and clear-to-RESET_VAL. It is instantiated for main and skid; the handshake control lives in the top module.

Test Plan:
- Reset then stream: reset 2 cycles; in_valid=1 with in_data=1,2,3 on consecutive cycles, out_ready=1 -> out_valid rises 1 cycle after first accept; out_data=1,2,3 on consecutive cycles; occ stays 1; in_ready always 1.
- Stall with skid (SKID=1): main holds 0xA, out_ready=0, accept 0xB -> occ=2, in_ready=0; 0xC held upstream. Raise out_ready -> out_data 0xA, 0xB, 0xC in order, no gaps, no loss.
- Stall without skid (SKID=0): out_ready=0 with main=0x5 -> in_ready=0 in the same cycle; out_data=0x5 stable for 4 cycles; release -> next accept is visible 1 cycle later.
- Flush with occ=2 and a simultaneous accept of 0x7 -> next cycle out_valid=0, occ=0, out_data=RESET_VAL, 0x7 never appears at the output, in_ready=1.
- Flush during issue: out_ready=1, flush=1, main=0x9 -> 0x9 counted as issued that cycle; nothing valid afterwards.
- Reset during a stall with occ=2 and flush=1 -> all outputs at reset values next cycle; no stale payload is ever re-issued.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared stage payload layouts for the five-stage MIPS core pipeline registers.
// Field widths, per-stage payload widths, NOP reset payloads and pack/unpack helpers.
package pipe_stage_reg_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ADDR_W  = 5;

  // sll $0,$0,0 encodes as all zeros
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [WORD_W-1:0]  pc;
  } if_id_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [WORD_W-1:0]  rs_data;
    logic [WORD_W-1:0]  rt_data;
    logic [WORD_W-1:0]  imm;
    logic [WORD_W-1:0]  pc;
    logic               we;
    logic [ADDR_W-1:0]  waddr;
  } id_ex_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [WORD_W-1:0]  alu;
    logic [WORD_W-1:0]  rt_data;
    logic [WORD_W-1:0]  pc;
    logic               we;
    logic [ADDR_W-1:0]  waddr;
  } ex_mem_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [WORD_W-1:0]  pc;
    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [WORD_W-1:0]  wdata;
  } mem_wb_t;

  localparam int unsigned IF_ID_W  = INSTR_W + WORD_W;
  localparam int unsigned ID_EX_W  = INSTR_W + 4 * WORD_W + 1 + ADDR_W;
  localparam int unsigned EX_MEM_W = INSTR_W + 3 * WORD_W + 1 + ADDR_W;
  localparam int unsigned MEM_WB_W = INSTR_W + 2 * WORD_W + 1 + ADDR_W;

  // Instruction is the most significant field in every layout.
  localparam logic [IF_ID_W-1:0]  IF_ID_NOP  = {NOP_INSTR, {(IF_ID_W - INSTR_W){1'b0}}};
  localparam logic [ID_EX_W-1:0]  ID_EX_NOP  = {NOP_INSTR, {(ID_EX_W - INSTR_W){1'b0}}};
  localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = {NOP_INSTR, {(EX_MEM_W - INSTR_W){1'b0}}};
  localparam logic [MEM_WB_W-1:0] MEM_WB_NOP = {NOP_INSTR, {(MEM_WB_W - INSTR_W){1'b0}}};

  function automatic logic [IF_ID_W-1:0] pack_if_id(input logic [INSTR_W-1:0] instr,
                                                    input logic [WORD_W-1:0]  pc);
    if_id_t f;
    f.instr = instr;
    f.pc    = pc;
    return IF_ID_W'(f);
  endfunction

  function automatic if_id_t unpack_if_id(input logic [IF_ID_W-1:0] v);
    return if_id_t'(v);
  endfunction

  function automatic logic [ID_EX_W-1:0] pack_id_ex(input logic [INSTR_W-1:0] instr,
                                                    input logic [WORD_W-1:0]  rs_data,
                                                    input logic [WORD_W-1:0]  rt_data,
                                                    input logic [WORD_W-1:0]  imm,
                                                    input logic [WORD_W-1:0]  pc,
                                                    input logic               we,
                                                    input logic [ADDR_W-1:0]  waddr);
    id_ex_t f;
    f.instr   = instr;
    f.rs_data = rs_data;
    f.rt_data = rt_data;
    f.imm     = imm;
    f.pc      = pc;
    f.we      = we;
    f.waddr   = waddr;
    return ID_EX_W'(f);
  endfunction

  function automatic id_ex_t unpack_id_ex(input logic [ID_EX_W-1:0] v);
    return id_ex_t'(v);
  endfunction

  function automatic logic [EX_MEM_W-1:0] pack_ex_mem(input logic [INSTR_W-1:0] instr,
                                                      input logic [WORD_W-1:0]  alu,
                                                      input logic [WORD_W-1:0]  rt_data,
                                                      input logic [WORD_W-1:0]  pc,
                                                      input logic               we,
                                                      input logic [ADDR_W-1:0]  waddr);
    ex_mem_t f;
    f.instr   = instr;
    f.alu     = alu;
    f.rt_data = rt_data;
    f.pc      = pc;
    f.we      = we;
    f.waddr   = waddr;
    return EX_MEM_W'(f);
  endfunction

  function automatic ex_mem_t unpack_ex_mem(input logic [EX_MEM_W-1:0] v);
    return ex_mem_t'(v);
  endfunction

  function automatic logic [MEM_WB_W-1:0] pack_mem_wb(input logic [INSTR_W-1:0] instr,
                                                      input logic [WORD_W-1:0]  pc,
                                                      input logic               we,
                                                      input logic [ADDR_W-1:0]  waddr,
                                                      input logic [WORD_W-1:0]  wdata);
    mem_wb_t f;
    f.instr = instr;
    f.pc    = pc;
    f.we    = we;
    f.waddr = waddr;
    f.wdata = wdata;
    return MEM_WB_W'(f);
  endfunction

  function automatic mem_wb_t unpack_mem_wb(input logic [MEM_WB_W-1:0] v);
    return mem_wb_t'(v);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One payload slot of a pipeline boundary register: load-enable, clear to RESET_VAL.
module pipe_entry
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned       DATA_W    = EX_MEM_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Clear outranks load so a squashed cycle never captures the incoming payload.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline boundary register with stall, flush and optional skid entry.
// out_data/out_valid are flop outputs; in_ready is registered only when SKID=1.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned       DATA_W    = EX_MEM_W,
  parameter bit                SKID      = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = EX_MEM_NOP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  logic              out_valid_q;
  logic              skid_valid_q;
  logic              in_ready_q;
  logic [1:0]        occ_q;

  logic              accept;
  logic              issue;
  logic              out_valid_nxt;
  logic              skid_valid_nxt;
  logic              main_load;
  logic              skid_load;
  logic              main_from_skid;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;

  assign in_ready = SKID ? in_ready_q : (out_ready | ~out_valid_q);
  assign accept   = in_valid & in_ready;
  assign issue    = out_valid_q & out_ready;

  // Next-state and load enables; a held skid entry always drains into main first.
  always_comb begin
    out_valid_nxt  = out_valid_q;
    skid_valid_nxt = skid_valid_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      out_valid_nxt  = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (SKID && skid_valid_q) begin
      if (issue) begin
        main_load      = 1'b1;
        main_from_skid = 1'b1;
        skid_valid_nxt = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || issue) begin
        main_load     = 1'b1;
        out_valid_nxt = 1'b1;
      end else if (SKID) begin
        skid_load      = 1'b1;
        skid_valid_nxt = 1'b1;
      end
    end else if (issue) begin
      out_valid_nxt = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      occ_q        <= 2'd0;
    end else begin
      out_valid_q  <= out_valid_nxt;
      skid_valid_q <= skid_valid_nxt;
      in_ready_q   <= ~skid_valid_nxt;
      occ_q        <= 2'({1'b0, out_valid_nxt}) + 2'({1'b0, skid_valid_nxt});
    end
  end

  pipe_entry #(
    .DATA_W   (DATA_W),
    .RESET_VAL(RESET_VAL)
  ) u_main (
    .clk  (clk),
    .reset(reset),
    .clear(flush),
    .load (main_load),
    .d    (main_d),
    .q    (out_data)
  );

  // Skid slot never loads when SKID=0 and collapses to a constant.
  pipe_entry #(
    .DATA_W   (DATA_W),
    .RESET_VAL(RESET_VAL)
  ) u_skid (
    .clk  (clk),
    .reset(reset),
    .clear(flush),
    .load (skid_load),
    .d    (in_data),
    .q    (skid_q)
  );

  assign out_valid = out_valid_q;
  assign occ       = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance against a queue model,
// directed scenarios with literal expectations followed by randomized traffic.
module tb_pipe_stage_reg;

  localparam int unsigned    DW  = 16;
  localparam logic [DW-1:0]  RV0 = 16'h0000;
  localparam logic [DW-1:0]  RV1 = 16'hA5A5;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          out_ready;
  logic [1:0]    in_valid;
  logic [1:0]    in_ready;
  logic [1:0]    out_valid;
  logic [DW-1:0] in_data  [2];
  logic [DW-1:0] out_data [2];
  logic [1:0]    occ      [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b0), .RESET_VAL(RV0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
    .occ(occ[0])
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b1), .RESET_VAL(RV1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
    .occ(occ[1])
  );

  // Model: each instance is a FIFO of capacity 1 (SKID=0) or 2 (SKID=1) plus the last shown value.
  logic [DW-1:0] mq    [2][$];
  logic [DW-1:0] mshow [2];
  bit            model_live = 1'b0;

  function automatic bit exp_ready(input int i);
    if (i == 1) return mq[1].size() < 2;
    return (mq[0].size() == 0) || (out_ready == 1'b1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model_step
    bit acc;
    bit iss;
    for (int i = 0; i < 2; i++) begin
      acc = (in_valid[i] == 1'b1) && exp_ready(i);
      iss = (mq[i].size() > 0) && (out_ready == 1'b1);
      if (reset || flush) begin
        mq[i].delete();
        mshow[i] = (i == 0) ? RV0 : RV1;
      end else begin
        if (iss) void'(mq[i].pop_front());
        if (acc) mq[i].push_back(in_data[i]);
        if (mq[i].size() > 0) mshow[i] = mq[i][0];
      end
    end
    if (reset) model_live = 1'b1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("out_valid%0d", i), 32'(out_valid[i]), 32'(mq[i].size() > 0));
        chk($sformatf("out_data%0d", i), 32'(out_data[i]), 32'(mshow[i]));
        chk($sformatf("occ%0d", i), 32'(occ[i]), 32'(mq[i].size()));
        chk($sformatf("in_ready%0d", i), 32'(in_ready[i]), 32'(exp_ready(i)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 2'b00;
    in_data[0] = '0; in_data[1] = '0;
    tick(); tick();
    reset = 1'b0;
    at_neg();
    chk("rst_out_valid0", 32'(out_valid[0]), 0);
    chk("rst_out_valid1", 32'(out_valid[1]), 0);
    chk("rst_occ1", 32'(occ[1]), 0);
    chk("rst_data0", 32'(out_data[0]), 32'h0000);
    chk("rst_data1", 32'(out_data[1]), 32'hA5A5);
    chk("rst_in_ready1", 32'(in_ready[1]), 1);

    // stream 1,2,3 at full rate
    in_valid = 2'b11; in_data[0] = 16'd1; in_data[1] = 16'd1;
    tick(); in_data[0] = 16'd2; in_data[1] = 16'd2;
    at_neg();
    chk("stream_valid1", 32'(out_valid[1]), 1);
    chk("stream_d1_0", 32'(out_data[0]), 1);
    chk("stream_d1_1", 32'(out_data[1]), 1);
    tick(); in_data[0] = 16'd3; in_data[1] = 16'd3;
    at_neg();
    chk("stream_d2_1", 32'(out_data[1]), 2);
    chk("stream_occ_1", 32'(occ[1]), 1);
    tick(); in_valid = 2'b00;
    at_neg();
    chk("stream_d3_0", 32'(out_data[0]), 3);
    chk("stream_d3_1", 32'(out_data[1]), 3);
    tick();
    at_neg();
    chk("stream_drained1", 32'(out_valid[1]), 0);
    chk("stream_hold_data1", 32'(out_data[1]), 3);

    // skid fill under stall, then drain A,B,C in order
    tick(); out_ready = 1'b0; in_valid = 2'b10; in_data[1] = 16'h000A;
    tick(); in_data[1] = 16'h000B;
    at_neg();
    chk("skid_mainA", 32'(out_data[1]), 32'hA);
    tick(); in_data[1] = 16'h000C;
    at_neg();
    chk("skid_occ2", 32'(occ[1]), 2);
    chk("skid_not_ready", 32'(in_ready[1]), 0);
    tick();
    at_neg();
    chk("skid_hold_A", 32'(out_data[1]), 32'hA);
    tick(); out_ready = 1'b1;
    at_neg();
    chk("drain_A", 32'(out_data[1]), 32'hA);
    tick();
    at_neg();
    chk("drain_B", 32'(out_data[1]), 32'hB);
    chk("drain_ready", 32'(in_ready[1]), 1);
    tick(); in_valid = 2'b00;
    at_neg();
    chk("drain_C", 32'(out_data[1]), 32'hC);
    chk("drain_C_valid", 32'(out_valid[1]), 1);
    tick();
    at_neg();
    chk("drain_empty", 32'(out_valid[1]), 0);

    // single-entry stall: combinational back-pressure and stable data
    tick(); out_ready = 1'b0; in_valid = 2'b01; in_data[0] = 16'h0005;
    tick(); in_data[0] = 16'h0006;
    at_neg();
    chk("nsk_ready_low", 32'(in_ready[0]), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      at_neg();
      chk($sformatf("nsk_hold%0d", k), 32'(out_data[0]), 32'h5);
    end
    tick(); out_ready = 1'b1;
    at_neg();
    chk("nsk_ready_release", 32'(in_ready[0]), 1);
    tick(); in_valid = 2'b00;
    at_neg();
    chk("nsk_next", 32'(out_data[0]), 32'h6);
    tick();

    // flush with occ=2 and an offered 0x7
    tick(); out_ready = 1'b0; in_valid = 2'b10; in_data[1] = 16'h0011;
    tick(); in_data[1] = 16'h0012;
    tick();
    at_neg();
    chk("fl_occ2", 32'(occ[1]), 2);
    tick(); flush = 1'b1; in_valid = 2'b11; in_data[0] = 16'h0007; in_data[1] = 16'h0007;
    tick(); flush = 1'b0; in_valid = 2'b00; out_ready = 1'b1;
    at_neg();
    chk("fl_valid0", 32'(out_valid[0]), 0);
    chk("fl_valid1", 32'(out_valid[1]), 0);
    chk("fl_occ1", 32'(occ[1]), 0);
    chk("fl_data1", 32'(out_data[1]), 32'hA5A5);
    chk("fl_ready1", 32'(in_ready[1]), 1);
    tick();
    at_neg();
    chk("fl_no7", 32'(out_valid[0]), 0);

    // flush during issue of 0x9
    tick(); out_ready = 1'b0; in_valid = 2'b11; in_data[0] = 16'h0009; in_data[1] = 16'h0009;
    tick(); in_valid = 2'b00; out_ready = 1'b1; flush = 1'b1;
    at_neg();
    chk("fi_pres0", 32'(out_data[0]), 32'h9);
    chk("fi_pres1", 32'(out_valid[1]), 1);
    tick(); flush = 1'b0;
    at_neg();
    chk("fi_after0", 32'(out_valid[0]), 0);
    chk("fi_after1", 32'(occ[1]), 0);

    // reset with flush during a full stall
    tick(); out_ready = 1'b0; in_valid = 2'b10; in_data[1] = 16'h0021;
    tick(); in_data[1] = 16'h0022;
    tick(); reset = 1'b1; flush = 1'b1; in_valid = 2'b11; in_data[0] = 16'h0033; in_data[1] = 16'h0033;
    at_neg();
    chk("rs_occ2", 32'(occ[1]), 2);
    tick(); reset = 1'b0; flush = 1'b0; in_valid = 2'b00; out_ready = 1'b1;
    at_neg();
    chk("rs_valid1", 32'(out_valid[1]), 0);
    chk("rs_occ1", 32'(occ[1]), 0);
    chk("rs_data1", 32'(out_data[1]), 32'hA5A5);
    chk("rs_ready1", 32'(in_ready[1]), 1);
    tick(); tick();
    at_neg();
    chk("rs_no_stale", 32'(out_valid[1]), 0);

    // randomized traffic with changing back-pressure density
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = 2'($urandom_range(0, 3));
      in_data[0] = 16'($urandom);
      in_data[1] = 16'($urandom);
      out_ready = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
    end
    tick();
    at_neg();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
